sys_bridge: RTL and testbench
=============================

# sys_bridge

Parametrised system bridge between the CPU memory-stage port and N memory-mapped slaves (DM, timer, UART, switches, LEDs, tubes, keys). It decodes the address against per-slave windows, issues a single-cycle strobe with an offset address, waits a per-slave number of cycles, and returns registered read data with a ready/error handshake. It also synchronises device interrupt lines into the CPU `HWInt` vector. It replaces the fixed combinational decode in the board top level.

## Interface
- `N_SLV`, 8: number of slave windows.
- `DW`, 32: data width (multiple of 8).
- `BASE`, packed `N_SLV*32`: window base per slave (slave i at bits `[32i+31:32i]`).
- `LIMIT`, packed `N_SLV*32`: inclusive window top per slave.
- `WAIT`, packed `N_SLV*4`: extra wait cycles per slave, 0–15.
- `IRQW`, 6: interrupt line count.
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: access request, sampled only in IDLE.
- `cpu_we` in 1: write when 1.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in DW: write data.
- `cpu_be` in DW/8: byte enables.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_ready`; set when no window matched.
- `cpu_rdata` out DW: registered read data, held until next completion.
- `err_addr` out 32: address of the most recent unmatched access.
- `slv_sel` out N_SLV: one-hot strobe.
- `slv_we` out 1: write qualifier for `slv_sel`.
- `slv_addr` out 32: `cpu_addr - BASE[i]`.
- `slv_wdata` out DW, `slv_be` out DW/8: latched write data and enables.
- `slv_rdata` in `N_SLV*DW`: packed slave read buses.
- `dev_irq` in IRQW: asynchronous device interrupts.
- `hwint` out IRQW: synchronised interrupts for CPU `HWInt`.

## Operation
- FSM states: IDLE, ACCESS, WAITS, DONE.
- IDLE with `cpu_req`=1:
  - Latch address, data, be, we.
  - Decode `BASE[i] <= addr <= LIMIT[i]`; on overlap the lowest index wins.
  - Match: go to ACCESS and load the counter with `WAIT[i]`.
  - No match: go to DONE with the error flag set and latch `err_addr`.
- ACCESS (exactly one cycle):
  - `slv_sel[i]`=1 and `slv_we`=latched we; all other cycles drive `slv_sel`=0.
  - Counter 0: sample `slv_rdata[i]` into `cpu_rdata` and go to DONE.
  - Counter nonzero: go to WAITS.
- WAITS: decrement the counter each cycle. When it reaches 0, sample `slv_rdata[i]` and go to DONE.
- DONE:
  - `cpu_ready`=1 for one cycle, then return to IDLE.
  - On error, `cpu_err`=1 and `cpu_rdata`=`32'hFFFF_FFFF`.
  - On a successful write, `cpu_rdata` is left unchanged.
- `cpu_req` in any state other than IDLE is ignored. The CPU must hold the request until `cpu_ready`.
- `hwint` = `dev_irq` passed through a 2-flop synchroniser per bit; level, not latched.
- Reset values:
  - State IDLE.
  - `cpu_ready`, `cpu_err`, `slv_sel`, `slv_we`, `hwint` = 0.
  - `cpu_rdata`, `err_addr`, `slv_addr`, `slv_wdata`, `slv_be` = 0.
  - Reset during any access aborts it immediately; no strobe is issued after reset deasserts.

## Timing
- Request sampled at cycle 0 edge; strobe in cycle 1.
- `cpu_ready` in cycle `WAIT[i]+2`.
- Error `cpu_ready` in cycle 1.
- Minimum request-to-request spacing: `WAIT[i]+3` cycles (matched) or 2 cycles (error).
- `slv_rdata[i]` must be valid by the end of cycle `WAIT[i]+1`. Synchronous-RAM slaves use `WAIT`≥1.
- `hwint` latency from `dev_irq`: 2 cycles.
- Counter is 4 bits; `WAIT`=15 gives ready at cycle 17, with no wrap.

## Structure
- Package `bridge_pkg`:
  - State enum.
  - `ERR_RDATA` = `32'hFFFF_FFFF`.
  - Default window constants for DM `0x0000–0x1FFF`, timer `0x7F00–0x7F0B`, UART `0x7F10–0x7F2B`, switches `0x7F2C–0x7F33`, LED `0x7F34–0x7F37`, tube `0x7F38–0x7F3F`, key `0x7F40–0x7F43`.
- Sub-module `irq_sync`: a parametrised-width 2-flop synchroniser, reset to 0.

## Test plan
- DM window, `WAIT0`=1, write `0x10` data `0xDEADBEEF` be `4'hF`:
  - `slv_sel`=`8'h01`, `slv_we`=1 for one cycle at cycle 1, `slv_addr`=`0x10`.
  - `cpu_ready` at cycle 3, `cpu_err`=0.
- Timer window `0x7F00`, `WAIT1`=2, read `0x7F04` with `slv_rdata[1]`=`0x1234`:
  - `slv_addr`=4.
  - `cpu_rdata`=`0x1234` with `cpu_ready` at cycle 4.
- Read `0x5000` (unmapped):
  - Cycle 1: `cpu_ready`=1, `cpu_err`=1, `cpu_rdata`=`0xFFFFFFFF`, `err_addr`=`0x5000`.
  - `slv_sel` stays 0 throughout.
- Overlapping windows 0 and 1 both covering `0x100`: access to `0x100` selects slave 0 only.
- Assert `reset` in WAITS of a `WAIT`=15 access:
  - Outputs return to 0 and the state returns to IDLE immediately.
  - No `cpu_ready` and no second strobe after release.
- Pulse `dev_irq`=`6'b000010`: `hwint`=`6'b000010` two edges later, clearing two edges after `dev_irq` drops.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and default address map for the CPU-to-slave bridge.
// Slave order: DM, timer, UART, switches, LED, tube, key, unused.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAITS,
        ST_DONE
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    localparam logic [31:0] DM_BASE    = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT   = 32'h0000_1FFF;
    localparam logic [31:0] TMR_BASE   = 32'h0000_7F00;
    localparam logic [31:0] TMR_LIMIT  = 32'h0000_7F0B;
    localparam logic [31:0] UART_BASE  = 32'h0000_7F10;
    localparam logic [31:0] UART_LIMIT = 32'h0000_7F2B;
    localparam logic [31:0] SW_BASE    = 32'h0000_7F2C;
    localparam logic [31:0] SW_LIMIT   = 32'h0000_7F33;
    localparam logic [31:0] LED_BASE   = 32'h0000_7F34;
    localparam logic [31:0] LED_LIMIT  = 32'h0000_7F37;
    localparam logic [31:0] TUBE_BASE  = 32'h0000_7F38;
    localparam logic [31:0] TUBE_LIMIT = 32'h0000_7F3F;
    localparam logic [31:0] KEY_BASE   = 32'h0000_7F40;
    localparam logic [31:0] KEY_LIMIT  = 32'h0000_7F43;

    // Slot 7 has base above limit so it never matches.
    localparam logic [255:0] DEF_BASE = {
        32'hFFFF_FFFF, KEY_BASE, TUBE_BASE, LED_BASE,
        SW_BASE, UART_BASE, TMR_BASE, DM_BASE
    };

    localparam logic [255:0] DEF_LIMIT = {
        32'h0000_0000, KEY_LIMIT, TUBE_LIMIT, LED_LIMIT,
        SW_LIMIT, UART_LIMIT, TMR_LIMIT, DM_LIMIT
    };

    localparam logic [31:0] DEF_WAIT = 32'h0000_0001;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for asynchronous device interrupt lines.
module irq_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sys_bridge.sv
// Decodes CPU accesses onto N slave windows, sequences wait states
// and returns registered read data with a ready/error handshake.
module sys_bridge
    import bridge_pkg::*;
#(
    parameter int                  N_SLV = 8,
    parameter int                  DW    = 32,
    parameter logic [N_SLV*32-1:0] BASE  = DEF_BASE,
    parameter logic [N_SLV*32-1:0] LIMIT = DEF_LIMIT,
    parameter logic [N_SLV*4-1:0]  WAIT  = DEF_WAIT,
    parameter int                  IRQW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [DW/8-1:0]   cpu_be,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [DW-1:0]     cpu_rdata,
    output logic [31:0]       err_addr,
    output logic [N_SLV-1:0]  slv_sel,
    output logic              slv_we,
    output logic [31:0]       slv_addr,
    output logic [DW-1:0]     slv_wdata,
    output logic [DW/8-1:0]   slv_be,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [IRQW-1:0]   dev_irq,
    output logic [IRQW-1:0]   hwint
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_we;
    logic              r_ready;
    logic              r_err;
    logic [DW-1:0]     r_rdata;
    logic [31:0]       r_err_addr;
    logic [N_SLV-1:0]  r_sel;
    logic              r_swe;
    logic [31:0]       r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_be;

    logic              w_hit;
    logic [N_SLV-1:0]  w_onehot;
    logic [31:0]       w_off;
    logic [3:0]        w_wait;
    logic [IW-1:0]     w_idx;
    logic [DW-1:0]     w_rsel;
    logic              w_last;

    // Descending scan so the lowest matching index overwrites the rest.
    always_comb begin
        w_hit    = 1'b0;
        w_onehot = '0;
        w_off    = '0;
        w_wait   = '0;
        w_idx    = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (cpu_addr >= BASE[32*i +: 32] &&
                cpu_addr <= LIMIT[32*i +: 32]) begin
                w_hit       = 1'b1;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_off       = cpu_addr - BASE[32*i +: 32];
                w_wait      = WAIT[4*i +: 4];
                w_idx       = IW'(i);
            end
        end
    end

    assign w_rsel = slv_rdata[int'(r_idx)*DW +: DW];
    assign w_last = (r_state == ST_ACCESS && r_cnt == 4'd0) ||
                    (r_state == ST_WAITS  && r_cnt == 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_err_addr <= '0;
            r_sel      <= '0;
            r_swe      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            r_sel   <= '0;
            r_swe   <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                        r_be    <= cpu_be;
                        if (w_hit) begin
                            r_state <= ST_ACCESS;
                            r_sel   <= w_onehot;
                            r_swe   <= cpu_we;
                            r_addr  <= w_off;
                            r_cnt   <= w_wait;
                            r_idx   <= w_idx;
                        end else begin
                            r_state    <= ST_DONE;
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_rdata    <= DW'(ERR_RDATA);
                            r_err_addr <= cpu_addr;
                        end
                    end
                end
                ST_ACCESS, ST_WAITS: begin
                    if (r_state == ST_WAITS)
                        r_cnt <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        if (!r_we)
                            r_rdata <= w_rsel;
                    end else begin
                        r_state <= ST_WAITS;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ready = r_ready;
    assign cpu_err   = r_err;
    assign cpu_rdata = r_rdata;
    assign err_addr  = r_err_addr;
    assign slv_sel   = r_sel;
    assign slv_we    = r_swe;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign slv_be    = r_be;

    irq_sync #(.W(IRQW)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (dev_irq),
        .o_q   (hwint)
    );

endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: directed cases plus random traffic
// checked against a window-table reference model.
module tb_sys_bridge;

    localparam int N    = 8;
    localparam int DW   = 32;
    localparam int IRQW = 6;

    localparam logic [255:0] P_BASE = {
        32'h0000_8000, 32'h0000_7F38, 32'h0000_7F34, 32'h0000_7F2C,
        32'h0000_7F10, 32'h0000_0100, 32'h0000_7F00, 32'h0000_0000
    };
    localparam logic [255:0] P_LIMIT = {
        32'h0000_80FF, 32'h0000_7F3F, 32'h0000_7F37, 32'h0000_7F33,
        32'h0000_7F2B, 32'h0000_01FF, 32'h0000_7F0B, 32'h0000_1FFF
    };
    localparam logic [31:0] P_WAIT = 32'h75F3_0021;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic [DW/8-1:0]   cpu_be;
    logic              cpu_ready;
    logic              cpu_err;
    logic [DW-1:0]     cpu_rdata;
    logic [31:0]       err_addr;
    logic [N-1:0]      slv_sel;
    logic              slv_we;
    logic [31:0]       slv_addr;
    logic [DW-1:0]     slv_wdata;
    logic [DW/8-1:0]   slv_be;
    logic [N*DW-1:0]   slv_rdata;
    logic [IRQW-1:0]   dev_irq;
    logic [IRQW-1:0]   hwint;

    sys_bridge #(
        .N_SLV (N),
        .DW    (DW),
        .BASE  (P_BASE),
        .LIMIT (P_LIMIT),
        .WAIT  (P_WAIT),
        .IRQW  (IRQW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .err_addr  (err_addr),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_be    (slv_be),
        .slv_rdata (slv_rdata),
        .dev_irq   (dev_irq),
        .hwint     (hwint)
    );

    typedef struct {
        logic [7:0]  sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          t_req;
    } stb_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] eaddr;
        int          t_req;
        int          cyc_rdy;
    } rsp_t;

    stb_t        sq[$];
    rsp_t        rq[$];
    logic [5:0]  hist[$];
    logic [31:0] sdata[N];
    logic [31:0] m_rdata;
    int          cyc;
    int          checks;
    int          errors;
    bit          irq_rand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int i);
        return P_BASE[32*i +: 32];
    endfunction

    function automatic logic [31:0] limit_of(input int i);
        return P_LIMIT[32*i +: 32];
    endfunction

    function automatic int wait_of(input int i);
        return int'(P_WAIT[4*i +: 4]);
    endfunction

    function automatic int find_slv(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if (a >= base_of(i) && a <= limit_of(i))
                return i;
        return -1;
    endfunction

    task automatic pack_sdata();
        for (int i = 0; i < N; i++)
            slv_rdata[32*i +: 32] = sdata[i];
    endtask

    // Call just after a rising edge; the next edge samples the request.
    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        int   s;
        int   t;
        stb_t e_s;
        rsp_t e_r;
        s = find_slv(a);
        t = cyc + 1;
        if (s < 0) begin
            m_rdata = 32'hFFFF_FFFF;
            e_r = '{err: 1'b1, rdata: m_rdata, eaddr: a,
                    t_req: t, cyc_rdy: 1};
        end else begin
            e_s = '{sel: 8'(1 << s), we: we, addr: a - base_of(s),
                    wdata: wd, be: be, t_req: t};
            sq.push_back(e_s);
            if (!we)
                m_rdata = sdata[s];
            e_r = '{err: 1'b0, rdata: m_rdata, eaddr: 32'h0,
                    t_req: t, cyc_rdy: wait_of(s) + 2};
        end
        rq.push_back(e_r);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_be    = be;
    endtask

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        bit got;
        got = 1'b0;
        issue(we, a, wd, be);
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk);
            #2;
            if (irq_rand && $urandom_range(0, 3) == 0)
                dev_irq = IRQW'($urandom);
            got = cpu_ready;
        end
        chk("ready_timeout", 64'(got), 64'd1);
        cpu_req = 1'b0;
        @(posedge clk);
        #2;
        chk("rdata_hold", 64'(cpu_rdata), 64'(m_rdata));
    endtask

    always @(negedge clk) begin : mon
        stb_t s;
        rsp_t r;
        if (reset) begin
            sq.delete();
            rq.delete();
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
        end else begin
            if (slv_sel != '0) begin
                if (sq.size() == 0) begin
                    chk("stray_strobe", 64'(slv_sel), 64'd0);
                end else begin
                    s = sq.pop_front();
                    chk("strobe_sel", 64'(slv_sel), 64'(s.sel));
                    chk("strobe_we", 64'(slv_we), 64'(s.we));
                    chk("strobe_addr", 64'(slv_addr), 64'(s.addr));
                    chk("strobe_cycle", 64'(cyc - s.t_req + 1), 64'd1);
                    if (s.we) begin
                        chk("strobe_wdata", 64'(slv_wdata), 64'(s.wdata));
                        chk("strobe_be", 64'(slv_be), 64'(s.be));
                    end
                end
            end
            if (cpu_ready) begin
                if (rq.size() == 0) begin
                    chk("stray_ready", 64'(cpu_ready), 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_err", 64'(cpu_err), 64'(r.err));
                    chk("rsp_rdata", 64'(cpu_rdata), 64'(r.rdata));
                    chk("rsp_cycle", 64'(cyc - r.t_req + 1),
                        64'(r.cyc_rdy));
                    if (r.err)
                        chk("rsp_err_addr", 64'(err_addr), 64'(r.eaddr));
                end
            end
            hist.push_back(dev_irq);
            if (hist.size() > 3)
                void'(hist.pop_front());
            chk("hwint", 64'(hwint), 64'(hist[0]));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(cpu_ready), 64'd0);
        chk({tag, "_err"}, 64'(cpu_err), 64'd0);
        chk({tag, "_sel"}, 64'(slv_sel), 64'd0);
        chk({tag, "_we"}, 64'(slv_we), 64'd0);
        chk({tag, "_hwint"}, 64'(hwint), 64'd0);
        chk({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
        chk({tag, "_eaddr"}, 64'(err_addr), 64'd0);
        chk({tag, "_saddr"}, 64'(slv_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(slv_wdata), 64'd0);
        chk({tag, "_be"}, 64'(slv_be), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        int          s;
        logic [31:0] span;
        r = int'($urandom_range(0, 9));
        s = int'($urandom_range(0, N - 1));
        span = limit_of(s) - base_of(s) + 32'd1;
        if (r < 2) return base_of(s);
        if (r < 4) return limit_of(s);
        if (r < 7) return base_of(s) + ($urandom % span);
        if (r < 8) return limit_of(s) + 32'd1;
        if (r < 9) return $urandom & 32'h0000_FFFF;
        return $urandom;
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        irq_rand  = 1'b0;
        m_rdata   = '0;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        dev_irq   = '0;
        for (int i = 0; i < N; i++) sdata[i] = 32'h0;
        pack_sdata();

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2;

        // DM write, then timer read, unmapped read, overlap
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        sdata[1] = 32'h0000_1234;
        pack_sdata();
        access(1'b0, 32'h7F04, 32'h0, 4'h0);
        chk("timer_rdata", 64'(cpu_rdata), 64'h1234);
        access(1'b0, 32'h5000, 32'h0, 4'h0);
        chk("unmapped_eaddr", 64'(err_addr), 64'h5000);
        sdata[0] = 32'hA5A5_0100;
        sdata[2] = 32'h5A5A_0200;
        pack_sdata();
        access(1'b0, 32'h100, 32'h0, 4'h0);
        access(1'b0, 32'h200, 32'h0, 4'h0);

        // Reset in the middle of a 15-wait access
        issue(1'b0, 32'h7F34, 32'hCAFE_F00D, 4'h5);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk_zero("abort");
        @(posedge clk);
        #2 reset = 1'b0;
        m_rdata = '0;
        repeat (25) @(posedge clk);
        #2;
        chk("abort_rdata", 64'(cpu_rdata), 64'd0);
        access(1'b1, 32'h7F34, 32'h1357_9BDF, 4'h3);

        // Interrupt pulse through the synchroniser
        dev_irq = 6'b000010;
        @(posedge clk);
        #1 chk("irq_edge1", 64'(hwint), 64'd0);
        @(posedge clk);
        #1 chk("irq_set", 64'(hwint), 64'b000010);
        repeat (2) @(posedge clk);
        #2 dev_irq = '0;
        @(posedge clk);
        #1 chk("irq_hold", 64'(hwint), 64'b000010);
        @(posedge clk);
        #1 chk("irq_clear", 64'(hwint), 64'd0);
        @(posedge clk);
        #2;

        irq_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < N; i++) sdata[i] = $urandom;
            pack_sdata();
            access(1'($urandom), rand_addr(), $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        irq_rand = 1'b0;

        repeat (5) @(posedge clk);
        #2;
        chk("queues_drained", 64'(sq.size() + rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
